l1_memory_banked: RTL and testbench
===================================

// Module: l1_memory_banked
//
// PURPOSE
//   Next-generation L1 data memory: a byte-enable, low-order-interleaved banked SRAM.
//   Port A is read/write and port B is read-only.
//   Adds a configurable pipelined read latency, bank-conflict stalls with a delay
//   handshake on port B, selectable read-during-write semantics, and read-valid strobes.
//   Sits between the core's load/store unit (A) and a secondary reader such as a
//   fetch or DMA engine (B).
//
// PARAMETERS
//   ADDR_WIDTH    10  word address width; total depth 2**ADDR_WIDTH words
//   DATA_WIDTH    32  word width; multiple of 8; BYTE_COUNT = DATA_WIDTH/8
//   NUM_BANKS     4   power of two, 1..2**ADDR_WIDTH; BANK_BITS = log2(NUM_BANKS)
//   READ_LATENCY  1   1 or 2; cycles from accepted read to data/valid
//   RDW_NEW_DATA  0   0: B reading the address A writes gets old word; 1: gets merged new word
//
// PORTS
//   clk         in   1           clock, all state on rising edge
//   reset       in   1           asynchronous, active-low reset
//   a_en        in   1           port A request
//   a_we        in   1           port A write (qualified by a_en)
//   a_be        in   BYTE_COUNT  port A byte enables (qualified by a_we)
//   a_addr      in   ADDR_WIDTH  port A word address
//   a_data_w    in   DATA_WIDTH  port A write data
//   a_data_r    out  DATA_WIDTH  port A read data
//   a_valid     out  1           a_data_r carries result of an accepted A read
//   a_delay     out  1           constant 0; A always has priority
//   b_en        in   1           port B read request
//   b_addr      in   ADDR_WIDTH  port B word address
//   b_data_r    out  DATA_WIDTH  port B read data
//   b_valid     out  1           b_data_r carries result of an accepted B read
//   b_delay     out  1           B request not accepted this cycle; hold and retry
//
// BEHAVIOUR
//   - Address split: bank = addr[BANK_BITS-1:0], row = addr[ADDR_WIDTH-1:BANK_BITS].
//     With NUM_BANKS=1 the bank is always 0 and row = addr.
//   - One access per bank per cycle.
//     Conflict = a_en & b_en & same bank & different row.
//   - Conflict handling: b_delay=1, combinational, same cycle; the B access is dropped.
//     The requester holds b_en/b_addr until b_delay=0.
//     Otherwise b_delay=0; it never asserts when b_en=0.
//   - Same bank and same row is not a conflict; both ports are served by one array read.
//   - Write: on a_en&a_we the byte lanes with a_be[i]=1 are written at the clock edge.
//     Other lanes keep their contents. a_be=0 with a_we=1 is a legal no-op write.
//   - A write returns no read data: a_valid stays 0 for that request.
//     A read-modify-write does not exist at the port.
//   - B read of the address A writes in the same cycle:
//     RDW_NEW_DATA=0 returns the pre-write word.
//     RDW_NEW_DATA=1 returns the merged word (new lanes where a_be=1, old elsewhere).
//   - Latency: an accepted read at edge N gives x_data_r/x_valid=1 after edge
//     N+READ_LATENCY-1+1, i.e. the next edge for latency 1 and two edges later for latency 2.
//     x_valid is a one-cycle strobe per accepted read.
//   - Back-to-back reads pipeline at full rate: one result per cycle per port.
//   - x_data_r holds its last value when x_valid=0; it is not cleared.
//   - Reset (reset=0, asynchronous):
//     - a_data_r=0, b_data_r=0, a_valid=0, b_valid=0 immediately.
//     - All in-flight pipeline stages are flushed.
//     - Array contents are NOT reset and survive reset.
//     - Requests presented while reset=0 are ignored; no writes take place.
//   - Reset release is synchronous to clk via an internal two-flop synchroniser.
//     Requests are accepted from the first edge after deassertion is synchronised.
//   - Out-of-range parameters (READ_LATENCY not 1/2, DATA_WIDTH%8≠0,
//     NUM_BANKS not a power of two) cause an elaboration error.
//
// TESTING
//   Defaults unless stated: DATA_WIDTH=32, NUM_BANKS=4, READ_LATENCY=1.
//   1. A writes 0xDEADBEEF to addr 5 with be=4'hF, then A reads addr 5
//      -> next cycle a_valid=1, a_data_r=0xDEADBEEF; a_valid=0 on the write cycle.
//   2. Over addr 5, A writes 0x11223344 with be=4'b0101, then reads it
//      -> a_data_r=0xDE22BE44.
//   3. Same cycle: A reads addr 4 and B reads addr 8 (both bank 0)
//      -> b_delay=1 that cycle.
//      B holds; next cycle, with A idle, b_delay=0 and b_valid=1 one cycle later
//      with mem[8].
//      Repeat with A on addr 4 and B on addr 5 -> no delay; both valid together.
//   4. Addr 5 holds 0xDE22BE44. Same cycle: A writes 0xCAFEF00D (be=4'hF) to addr 5
//      and B reads addr 5.
//      -> RDW_NEW_DATA=0: b_data_r=0xDE22BE44; RDW_NEW_DATA=1: b_data_r=0xCAFEF00D.
//   5. READ_LATENCY=2: A issues reads of addrs 0..7 on consecutive cycles
//      -> 8 consecutive a_valid strobes starting 2 cycles after the first request,
//      data in order.
//   6. READ_LATENCY=2: issue an A read, then assert reset=0 mid-cycle before the data returns
//      -> a_valid/b_valid and both data_r drop to 0 asynchronously; no strobe appears.
//      After release, reading a previously written address returns its pre-reset contents.

Source files
------------

// File: rtl/l1_memory_banked.sv
// Low-order-interleaved banked L1 data memory: port A read/write with byte enables,
// port B read-only with conflict delay, pipelined read latency of 1 or 2 cycles.
module l1_memory_banked #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_BANKS    = 4,
    parameter int READ_LATENCY = 1,
    parameter int RDW_NEW_DATA = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_en,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_data_w,
    output logic [DATA_WIDTH-1:0]   a_data_r,
    output logic                    a_valid,
    output logic                    a_delay,
    input  logic                    b_en,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_data_r,
    output logic                    b_valid,
    output logic                    b_delay
);

    localparam int unsigned BYTE_COUNT = DATA_WIDTH / 8;
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int ROW_W     = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int ROWS      = 2 ** ROW_BITS;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("l1_memory_banked: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("l1_memory_banked: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 || NUM_BANKS > 2 ** ADDR_WIDTH) begin : g_bad_banks
        $error("l1_memory_banked: NUM_BANKS must be a power of two in 1..2**ADDR_WIDTH");
    end

    logic [BANK_W-1:0] a_bank, b_bank;
    logic [ROW_W-1:0]  a_row, b_row;

    if (BANK_BITS == 0) begin : g_single_bank
        assign a_bank = '0;
        assign b_bank = '0;
        assign a_row  = a_addr;
        assign b_row  = b_addr;
    end else if (ROW_BITS == 0) begin : g_single_row
        assign a_bank = a_addr;
        assign b_bank = b_addr;
        assign a_row  = '0;
        assign b_row  = '0;
    end else begin : g_split
        assign a_bank = a_addr[BANK_BITS-1:0];
        assign b_bank = b_addr[BANK_BITS-1:0];
        assign a_row  = a_addr[ADDR_WIDTH-1:BANK_BITS];
        assign b_row  = b_addr[ADDR_WIDTH-1:BANK_BITS];
    end

    // Reset asserts asynchronously but releases only after two clock edges.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][ROWS];
    logic                  a_wr, a_rd, b_rd;
    logic [DATA_WIDTH-1:0] a_word, b_word;

    assign a_delay = 1'b0;
    assign b_delay = a_en & b_en & (a_bank == b_bank) & (a_row != b_row);
    assign a_wr    = rst_n_int & a_en & a_we;
    assign a_rd    = rst_n_int & a_en & ~a_we;
    assign b_rd    = rst_n_int & b_en & ~b_delay;

    // Same-address B read sees either the stored word or the lane-merged write word.
    always_comb begin
        a_word = mem[a_bank][a_row];
        b_word = mem[b_bank][b_row];
        if (RDW_NEW_DATA != 0 && a_wr && a_addr == b_addr) begin
            for (int unsigned i = 0; i < BYTE_COUNT; i++) begin
                if (a_be[i]) b_word[i*8 +: 8] = a_data_w[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_wr) begin
            for (int unsigned i = 0; i < BYTE_COUNT; i++) begin
                if (a_be[i]) mem[a_bank][a_row][i*8 +: 8] <= a_data_w[i*8 +: 8];
            end
        end
    end

    logic                  a_v1, b_v1;
    logic [DATA_WIDTH-1:0] a_d1, b_d1;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
            a_d1 <= '0;
            b_d1 <= '0;
        end else begin
            a_v1 <= a_rd;
            b_v1 <= b_rd;
            if (a_rd) a_d1 <= a_word;
            if (b_rd) b_d1 <= b_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  a_v2, b_v2;
        logic [DATA_WIDTH-1:0] a_d2, b_d2;

        always_ff @(posedge clk or negedge rst_n_int) begin
            if (!rst_n_int) begin
                a_v2 <= 1'b0;
                b_v2 <= 1'b0;
                a_d2 <= '0;
                b_d2 <= '0;
            end else begin
                a_v2 <= a_v1;
                b_v2 <= b_v1;
                if (a_v1) a_d2 <= a_d1;
                if (b_v1) b_d2 <= b_d1;
            end
        end

        assign a_valid  = a_v2;
        assign b_valid  = b_v2;
        assign a_data_r = a_d2;
        assign b_data_r = b_d2;
    end else begin : g_lat1
        assign a_valid  = a_v1;
        assign b_valid  = b_v1;
        assign a_data_r = a_d1;
        assign b_data_r = b_d1;
    end

endmodule

// File: tb/tb_l1_memory_banked.sv
// Directed bench for l1_memory_banked: x0 is latency 1 / old-data RDW,
// x1 is latency 2 / new-data RDW, both driven by the same request stream.
module tb_l1_memory_banked;

    logic        clk;
    logic        reset;
    logic        a_en, a_we, b_en;
    logic [3:0]  a_be;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_data_w;

    logic [31:0] x0_a_data_r, x0_b_data_r, x1_a_data_r, x1_b_data_r;
    logic        x0_a_valid, x0_a_delay, x0_b_valid, x0_b_delay;
    logic        x1_a_valid, x1_a_delay, x1_b_valid, x1_b_delay;

    int checks;
    int errors;

    l1_memory_banked #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_BANKS(4),
                       .READ_LATENCY(1), .RDW_NEW_DATA(0)) x0 (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_data_w(a_data_w),
        .a_data_r(x0_a_data_r), .a_valid(x0_a_valid), .a_delay(x0_a_delay),
        .b_en(b_en), .b_addr(b_addr),
        .b_data_r(x0_b_data_r), .b_valid(x0_b_valid), .b_delay(x0_b_delay)
    );

    l1_memory_banked #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_BANKS(4),
                       .READ_LATENCY(2), .RDW_NEW_DATA(1)) x1 (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_data_w(a_data_w),
        .a_data_r(x1_a_data_r), .a_valid(x1_a_valid), .a_delay(x1_a_delay),
        .b_en(b_en), .b_addr(b_addr),
        .b_data_r(x1_b_data_r), .b_valid(x1_b_valid), .b_delay(x1_b_delay)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_en = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = '0; a_data_w = '0;
        b_en = 1'b0; b_addr = '0;
    endtask

    task automatic a_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be);
        a_en = 1'b1; a_we = 1'b1; a_be = be; a_addr = addr; a_data_w = data;
    endtask

    task automatic a_read(input logic [9:0] addr);
        a_en = 1'b1; a_we = 1'b0; a_be = 4'h0; a_addr = addr; a_data_w = '0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++; if (x0_a_valid !== 1'b0) begin errors++; $display("FAIL reset_x0_a_valid: got %b want 0", x0_a_valid); end
        checks++; if (x0_b_valid !== 1'b0) begin errors++; $display("FAIL reset_x0_b_valid: got %b want 0", x0_b_valid); end
        checks++; if (x0_a_data_r !== 32'h0) begin errors++; $display("FAIL reset_x0_a_data: got %h want 0", x0_a_data_r); end
        checks++; if (x0_b_data_r !== 32'h0) begin errors++; $display("FAIL reset_x0_b_data: got %h want 0", x0_b_data_r); end
        checks++; if (x1_a_valid !== 1'b0) begin errors++; $display("FAIL reset_x1_a_valid: got %b want 0", x1_a_valid); end
        checks++; if (x1_b_data_r !== 32'h0) begin errors++; $display("FAIL reset_x1_b_data: got %h want 0", x1_b_data_r); end
        checks++; if (x0_a_delay !== 1'b0) begin errors++; $display("FAIL reset_a_delay: got %b want 0", x0_a_delay); end
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_write_read;
        idle(); tick();
        a_write(10'd5, 32'hDEADBEEF, 4'hF);
        tick();
        checks++; if (x0_a_valid !== 1'b0) begin errors++; $display("FAIL wr_no_valid_x0: got %b want 0", x0_a_valid); end
        a_read(10'd5);
        tick();
        checks++; if (x0_a_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_x0: got %b want 1", x0_a_valid); end
        checks++; if (x0_a_data_r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_x0: got %h want deadbeef", x0_a_data_r); end
        checks++; if (x1_a_valid !== 1'b0) begin errors++; $display("FAIL wr_no_valid_x1: got %b want 0", x1_a_valid); end
        idle();
        tick();
        checks++; if (x0_a_valid !== 1'b0) begin errors++; $display("FAIL strobe_once_x0: got %b want 0", x0_a_valid); end
        checks++; if (x0_a_data_r !== 32'hDEADBEEF) begin errors++; $display("FAIL data_hold_x0: got %h want deadbeef", x0_a_data_r); end
        checks++; if (x1_a_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_x1: got %b want 1", x1_a_valid); end
        checks++; if (x1_a_data_r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_x1: got %h want deadbeef", x1_a_data_r); end
        tick();
        checks++; if (x1_a_valid !== 1'b0) begin errors++; $display("FAIL strobe_once_x1: got %b want 0", x1_a_valid); end
    endtask

    task automatic test_byte_enable;
        idle(); tick();
        a_write(10'd5, 32'h11223344, 4'b0101);
        tick();
        a_read(10'd5);
        tick();
        checks++; if (x0_a_data_r !== 32'hDE22BE44) begin errors++; $display("FAIL be_merge_x0: got %h want de22be44", x0_a_data_r); end
        a_write(10'd5, 32'h99999999, 4'b0000);
        tick();
        checks++; if (x1_a_data_r !== 32'hDE22BE44) begin errors++; $display("FAIL be_merge_x1: got %h want de22be44", x1_a_data_r); end
        a_read(10'd5);
        tick();
        checks++; if (x0_a_data_r !== 32'hDE22BE44) begin errors++; $display("FAIL be_zero_noop: got %h want de22be44", x0_a_data_r); end
        idle(); tick();
    endtask

    task automatic test_conflict;
        idle(); tick();
        a_write(10'd8, 32'h88888888, 4'hF); tick();
        a_write(10'd4, 32'h44440004, 4'hF); tick();
        a_read(10'd4); b_en = 1'b0; b_addr = 10'd8;
        #1;
        checks++; if (x0_b_delay !== 1'b0) begin errors++; $display("FAIL delay_without_b_en: got %b want 0", x0_b_delay); end
        b_en = 1'b1;
        #1;
        checks++; if (x0_b_delay !== 1'b1) begin errors++; $display("FAIL conflict_delay_x0: got %b want 1", x0_b_delay); end
        checks++; if (x1_b_delay !== 1'b1) begin errors++; $display("FAIL conflict_delay_x1: got %b want 1", x1_b_delay); end
        tick();
        checks++; if (x0_a_valid !== 1'b1 || x0_a_data_r !== 32'h44440004) begin errors++; $display("FAIL conflict_a_served: got %b/%h want 1/44440004", x0_a_valid, x0_a_data_r); end
        checks++; if (x0_b_valid !== 1'b0) begin errors++; $display("FAIL conflict_b_dropped: got %b want 0", x0_b_valid); end
        a_en = 1'b0;
        #1;
        checks++; if (x0_b_delay !== 1'b0) begin errors++; $display("FAIL retry_no_delay: got %b want 0", x0_b_delay); end
        tick();
        checks++; if (x0_b_valid !== 1'b1 || x0_b_data_r !== 32'h88888888) begin errors++; $display("FAIL retry_b_x0: got %b/%h want 1/88888888", x0_b_valid, x0_b_data_r); end
        checks++; if (x1_a_valid !== 1'b1 || x1_b_valid !== 1'b0) begin errors++; $display("FAIL conflict_x1_order: got a=%b b=%b want a=1 b=0", x1_a_valid, x1_b_valid); end
        b_en = 1'b0;
        tick();
        checks++; if (x1_b_valid !== 1'b1 || x1_b_data_r !== 32'h88888888) begin errors++; $display("FAIL retry_b_x1: got %b/%h want 1/88888888", x1_b_valid, x1_b_data_r); end
        checks++; if (x0_b_valid !== 1'b0) begin errors++; $display("FAIL retry_single_strobe: got %b want 0", x0_b_valid); end
        a_read(10'd4); b_en = 1'b1; b_addr = 10'd5;
        #1;
        checks++; if (x0_b_delay !== 1'b0) begin errors++; $display("FAIL diff_bank_delay: got %b want 0", x0_b_delay); end
        tick();
        checks++; if (x0_a_valid !== 1'b1 || x0_b_valid !== 1'b1) begin errors++; $display("FAIL dual_valid_x0: got a=%b b=%b want 1 1", x0_a_valid, x0_b_valid); end
        checks++; if (x0_a_data_r !== 32'h44440004 || x0_b_data_r !== 32'hDE22BE44) begin errors++; $display("FAIL dual_data_x0: got %h/%h want 44440004/de22be44", x0_a_data_r, x0_b_data_r); end
        a_read(10'd8); b_addr = 10'd8;
        #1;
        checks++; if (x0_b_delay !== 1'b0) begin errors++; $display("FAIL same_row_delay: got %b want 0", x0_b_delay); end
        tick();
        checks++; if (x1_a_valid !== 1'b1 || x1_b_valid !== 1'b1 || x1_b_data_r !== 32'hDE22BE44) begin errors++; $display("FAIL dual_x1: got %b %b %h want 1 1 de22be44", x1_a_valid, x1_b_valid, x1_b_data_r); end
        checks++; if (x0_a_data_r !== 32'h88888888 || x0_b_data_r !== 32'h88888888) begin errors++; $display("FAIL same_row_data: got %h/%h want 88888888/88888888", x0_a_data_r, x0_b_data_r); end
        idle(); tick(); tick();
    endtask

    task automatic test_rdw;
        idle(); tick();
        a_write(10'd5, 32'hCAFEF00D, 4'hF); b_en = 1'b1; b_addr = 10'd5;
        #1;
        checks++; if (x0_b_delay !== 1'b0) begin errors++; $display("FAIL rdw_delay: got %b want 0", x0_b_delay); end
        tick();
        checks++; if (x0_b_valid !== 1'b1 || x0_b_data_r !== 32'hDE22BE44) begin errors++; $display("FAIL rdw_old_x0: got %b/%h want 1/de22be44", x0_b_valid, x0_b_data_r); end
        checks++; if (x0_a_valid !== 1'b0) begin errors++; $display("FAIL rdw_a_no_valid: got %b want 0", x0_a_valid); end
        idle();
        tick();
        checks++; if (x1_b_valid !== 1'b1 || x1_b_data_r !== 32'hCAFEF00D) begin errors++; $display("FAIL rdw_new_x1: got %b/%h want 1/cafef00d", x1_b_valid, x1_b_data_r); end
        a_write(10'd5, 32'h0000AA00, 4'b0010); b_en = 1'b1; b_addr = 10'd5;
        tick();
        idle();
        tick();
        checks++; if (x1_b_data_r !== 32'hCAFEAA0D) begin errors++; $display("FAIL rdw_merge_x1: got %h want cafeaa0d", x1_b_data_r); end
        tick();
    endtask

    task automatic test_back_to_back;
        int strobes;
        strobes = 0;
        idle(); tick();
        for (int i = 0; i < 8; i++) begin
            a_write(10'(i), 32'h0A0B0C00 + 32'(i), 4'hF);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            if (k < 8) a_read(10'(k));
            else idle();
            tick();
            if (x1_a_valid === 1'b1) strobes++;
            checks++; if (x0_a_valid !== (k < 8)) begin errors++; $display("FAIL b2b_valid_x0[%0d]: got %b want %b", k, x0_a_valid, (k < 8)); end
            if (k < 8) begin
                checks++; if (x0_a_data_r !== 32'h0A0B0C00 + 32'(k)) begin errors++; $display("FAIL b2b_data_x0[%0d]: got %h want %h", k, x0_a_data_r, 32'h0A0B0C00 + 32'(k)); end
            end
            checks++; if (x1_a_valid !== (k >= 1 && k <= 8)) begin errors++; $display("FAIL b2b_valid_x1[%0d]: got %b want %b", k, x1_a_valid, (k >= 1 && k <= 8)); end
            if (k >= 1 && k <= 8) begin
                checks++; if (x1_a_data_r !== 32'h0A0B0C00 + 32'(k - 1)) begin errors++; $display("FAIL b2b_data_x1[%0d]: got %h want %h", k, x1_a_data_r, 32'h0A0B0C00 + 32'(k - 1)); end
            end
        end
        checks++; if (strobes != 8) begin errors++; $display("FAIL b2b_strobe_count: got %0d want 8", strobes); end
    endtask

    task automatic test_reset_midflight;
        idle(); tick();
        a_read(10'd3);
        tick();
        idle();
        #3 reset = 1'b0;
        #1;
        checks++; if (x0_a_valid !== 1'b0 || x0_a_data_r !== 32'h0) begin errors++; $display("FAIL mid_reset_x0: got %b/%h want 0/0", x0_a_valid, x0_a_data_r); end
        checks++; if (x1_a_valid !== 1'b0 || x1_a_data_r !== 32'h0) begin errors++; $display("FAIL mid_reset_x1: got %b/%h want 0/0", x1_a_valid, x1_a_data_r); end
        checks++; if (x0_b_data_r !== 32'h0 || x1_b_data_r !== 32'h0 || x1_b_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_b: got %h/%h/%b want 0/0/0", x0_b_data_r, x1_b_data_r, x1_b_valid); end
        a_write(10'd3, 32'hBAD0BAD0, 4'hF);
        tick();
        checks++; if (x1_a_valid !== 1'b0) begin errors++; $display("FAIL flushed_strobe_x1: got %b want 0", x1_a_valid); end
        a_read(10'd3);
        tick();
        checks++; if (x0_a_valid !== 1'b0 || x1_a_data_r !== 32'h0) begin errors++; $display("FAIL reset_ignores_req: got %b/%h want 0/0", x0_a_valid, x1_a_data_r); end
        idle();
        #3 reset = 1'b1;
        tick();
        tick();
        a_read(10'd3);
        tick();
        checks++; if (x0_a_valid !== 1'b1 || x0_a_data_r !== 32'h0A0B0C03) begin errors++; $display("FAIL survive_x0: got %b/%h want 1/0a0b0c03", x0_a_valid, x0_a_data_r); end
        idle();
        tick();
        checks++; if (x1_a_valid !== 1'b1 || x1_a_data_r !== 32'h0A0B0C03) begin errors++; $display("FAIL survive_x1: got %b/%h want 1/0a0b0c03", x1_a_valid, x1_a_data_r); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_conflict();
        test_rdw();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
